instr_fetch_unit: RTL

- Instruction-fetch stage directly upstream of the opcode/control decoder.
- Holds the PC and issues word addresses to the synchronous instruction memory (1-cycle read latency).
- Buffers returned words in a 2-entry output queue and presents them to decode with a valid/ready handshake.
- Applies branch/jump redirects from execute; opcode[4:0] = instr[31:27] is exported for the decoder.

---
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC sequencing, imem request issue and 2-entry fetch queue for decode
module instr_fetch_unit #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_plus1,
  output logic [4:0]        opcode,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]        state_q, state_n;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_pc;
  logic              req_vld;

  logic              hd_vld, tl_vld;
  logic [31:0]       hd_instr, tl_instr;
  logic [ADDR_W-1:0] hd_pc, tl_pc;

  logic              hd_vld_n, tl_vld_n;
  logic [31:0]       hd_instr_n, tl_instr_n;
  logic [ADDR_W-1:0] hd_pc_n, tl_pc_n;

  logic              pop;
  logic [1:0]        occ_after;
  logic              issue;

  assign pop = hd_vld & out_ready;

  // Slots committed after this edge: held entries minus the pop plus the word in flight.
  assign occ_after = {1'b0, hd_vld} + {1'b0, tl_vld} - {1'b0, pop} + {1'b0, req_vld};
  assign issue     = (state_q == RUN) & run & (occ_after <= 2'd1) & ~redirect;

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (run)  state_n = RUN;
      RUN:     if (!run) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    hd_vld_n   = hd_vld;
    hd_instr_n = hd_instr;
    hd_pc_n    = hd_pc;
    tl_vld_n   = tl_vld;
    tl_instr_n = tl_instr;
    tl_pc_n    = tl_pc;
    if (pop) begin
      hd_vld_n   = tl_vld;
      hd_instr_n = tl_instr;
      hd_pc_n    = tl_pc;
      tl_vld_n   = 1'b0;
    end
    if (req_vld) begin
      if (!hd_vld_n) begin
        hd_vld_n   = 1'b1;
        hd_instr_n = imem_q;
        hd_pc_n    = req_pc;
      end else begin
        tl_vld_n   = 1'b1;
        tl_instr_n = imem_q;
        tl_pc_n    = req_pc;
      end
    end
    if (redirect) begin
      hd_vld_n = 1'b0;
      tl_vld_n = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc   <= '0;
      req_vld  <= 1'b0;
      hd_vld   <= 1'b0;
      hd_instr <= '0;
      hd_pc    <= '0;
      tl_vld   <= 1'b0;
      tl_instr <= '0;
      tl_pc    <= '0;
    end else begin
      state_q  <= state_n;
      hd_vld   <= hd_vld_n;
      hd_instr <= hd_instr_n;
      hd_pc    <= hd_pc_n;
      tl_vld   <= tl_vld_n;
      tl_instr <= tl_instr_n;
      tl_pc    <= tl_pc_n;
      if (redirect) begin
        pc_q    <= redirect_pc;
        req_vld <= 1'b0;
      end else if (issue) begin
        pc_q    <= pc_q + ADDR_W'(1);
        req_pc  <= pc_q;
        req_vld <= 1'b1;
      end else begin
        req_vld <= 1'b0;
      end
    end
  end

  assign imem_addr    = pc_q;
  assign out_valid    = hd_vld;
  assign out_instr    = hd_instr;
  assign out_pc       = hd_pc;
  assign out_pc_plus1 = hd_pc + ADDR_W'(1);
  assign opcode       = hd_instr[31:27];

endmodule
